// File: rtl/mem_interconnect_rr.sv
// mem_interconnect_rr
// Core-to-memory interconnect. NUM_CORES request ports share one memory
// port through a round-robin arbiter. A grant is held for a burst of beats
// whose length comes from the first beat's access_length: 0 counts as 1,
// and anything above MAX_BURST is cut to MAX_BURST. Memory responses are
// registered once and routed back to the core named by core_id.
//
// Ports
//   clk           clock, all logic on posedge
//   reset         asynchronous active-low reset
//   core_req[i]   request from core i; .vld qualifies
//   core_req_rdy  bit i set when core i's beat is accepted this cycle
//   core_rsp[i]   registered one-cycle response pulse to core i
//   mem_req       arbitrated request to memory; all-zero when idle
//   mem_req_rdy   memory accepts mem_req this cycle
//   mem_rsp       memory response; .vld qualifies, .core_id selects the core
//   bad_id_cnt    saturating count of responses dropped for a bad core_id
//   dbg_state     arbiter state, 0 = IDLE, 1 = BURST
//
// Handshake: a beat transfers in a cycle where mem_req.vld and mem_req_rdy
// are both high. The same cycle raises core_req_rdy for the owning core.
// While mem_req_rdy is low the request stays on mem_req and the arbiter
// holds its state.
//
// Build option: define MEM_INTERCONNECT_BAD_ID_CNT_EN to include the
// bad_id_cnt counter. Without it bad_id_cnt is tied to zero.
//
// ID_W must not exceed the width of request_t.core_id.

package mem_interconnect_rr_pkg;
    localparam int CORE_ID_BITS = 4;

    typedef struct packed {
        logic                    vld;
        logic [CORE_ID_BITS-1:0] core_id;
        logic [7:0]              access_length;
        logic                    we;
        logic [31:0]             addr;
        logic [31:0]             data;
    } request_t;
endpackage

module mem_interconnect_rr
    import mem_interconnect_rr_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int MAX_BURST = 8,
    parameter int ID_W      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  request_t             core_req [NUM_CORES],
    output logic [NUM_CORES-1:0] core_req_rdy,
    output request_t             core_rsp [NUM_CORES],
    output request_t             mem_req,
    input  logic                 mem_req_rdy,
    input  request_t             mem_rsp,
    output logic [15:0]          bad_id_cnt,
    output logic                 dbg_state
);
    localparam int PTR_W  = $clog2(NUM_CORES);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  locked;
    logic [PTR_W-1:0]  sel;
    logic              found;
    logic [BEAT_W-1:0] beats_left;
    logic [BEAT_W-1:0] first_len;
    logic [31:0]       rsp_id;
    logic              rsp_id_ok;

    // Index after i, wrapping for NUM_CORES values that are not powers of 2.
    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
        if (int'(i) == NUM_CORES - 1) return '0;
        return i + PTR_W'(1);
    endfunction

    // First requesting core in the order ptr, ptr+1, ... (mod NUM_CORES).
    always_comb begin : arb_scan
        int idx;
        sel   = ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (!found && core_req[idx].vld) begin
                sel   = PTR_W'(idx);
                found = 1'b1;
            end
        end
    end

    // Burst length of the selected core's request after 0->1 and clipping.
    always_comb begin
        first_len = BEAT_W'(MAX_BURST);
        if (core_req[sel].access_length == 8'd0)
            first_len = BEAT_W'(1);
        else if (32'(core_req[sel].access_length) < 32'(MAX_BURST))
            first_len = BEAT_W'(core_req[sel].access_length);
    end

    // Request mux. It is combinational, and it is held at zero while reset is
    // asserted so nothing leaks out of the asynchronous reset window.
    always_comb begin
        mem_req      = '0;
        core_req_rdy = '0;
        if (reset) begin
            if (state == BURST) begin
                if (core_req[locked].vld) begin
                    mem_req              = core_req[locked];
                    core_req_rdy[locked] = mem_req_rdy;
                end
            end else if (found) begin
                mem_req           = core_req[sel];
                core_req_rdy[sel] = mem_req_rdy;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            locked     <= '0;
            beats_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found && mem_req_rdy) begin
                        if (first_len == BEAT_W'(1)) begin
                            ptr <= next_idx(sel);
                        end else begin
                            state      <= BURST;
                            locked     <= sel;
                            beats_left <= first_len - BEAT_W'(1);
                        end
                    end
                end
                BURST: begin
                    // When the owner drops vld, the rest of the burst is
                    // abandoned. This happens even if memory is stalling.
                    if (!core_req[locked].vld) begin
                        state      <= IDLE;
                        ptr        <= next_idx(locked);
                        beats_left <= '0;
                    end else if (mem_req_rdy) begin
                        beats_left <= beats_left - BEAT_W'(1);
                        if (beats_left == BEAT_W'(1)) begin
                            state <= IDLE;
                            ptr   <= next_idx(locked);
                        end
                    end
                end
            endcase
        end
    end

    assign dbg_state = (state == BURST);

    // Response routing. Every core_rsp is rewritten each cycle, so a response
    // shows up as a single-cycle pulse. An out-of-range id reaches no core.
    assign rsp_id    = 32'(mem_rsp.core_id[ID_W-1:0]);
    assign rsp_id_ok = (rsp_id < 32'(NUM_CORES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CORES; i++) core_rsp[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++)
                core_rsp[i] <= (mem_rsp.vld && rsp_id_ok && rsp_id == 32'(i)) ? mem_rsp : '0;
        end
    end

`ifdef MEM_INTERCONNECT_BAD_ID_CNT_EN
    logic [15:0] bad_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bad_cnt_q <= 16'h0000;
        else if (mem_rsp.vld && !rsp_id_ok && bad_cnt_q != 16'hFFFF)
            bad_cnt_q <= bad_cnt_q + 16'd1;
    end

    assign bad_id_cnt = bad_cnt_q;
`else
    assign bad_id_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_interconnect_rr.sv
// Bench for mem_interconnect_rr. It runs directed arbitration scenarios and
// then a randomized phase. Outputs are compared against a reference model
// that tracks grant ownership, the rotation pointer and the expected
// response pulses.
module tb_mem_interconnect_rr;
    import mem_interconnect_rr_pkg::*;

    localparam int N   = 4;
    localparam int MB  = 8;
    localparam int RW  = $bits(request_t);

    logic           clk;
    logic           reset;
    request_t       core_req [N];
    logic [N-1:0]   core_req_rdy;
    request_t       core_rsp [N];
    request_t       mem_req;
    logic           mem_req_rdy;
    request_t       mem_rsp;
    logic [15:0]    bad_id_cnt;
    logic           dbg_state;

    mem_interconnect_rr #(.NUM_CORES(N), .MAX_BURST(MB), .ID_W(4)) dut (
        .clk(clk), .reset(reset), .core_req(core_req), .core_req_rdy(core_req_rdy),
        .core_rsp(core_rsp), .mem_req(mem_req), .mem_req_rdy(mem_req_rdy),
        .mem_rsp(mem_rsp), .bad_id_cnt(bad_id_cnt), .dbg_state(dbg_state)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_ptr;
    int m_owner;
    int m_left;
    int m_bad;
    logic [RW-1:0] exp_q[$];
    logic [N-1:0]  last_rdy;
    int            acc_cnt [N];

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int clip(input int al);
        if (al == 0) return 1;
        if (al > MB) return MB;
        return al;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_owner = -1;
        m_left  = 0;
        m_bad   = 0;
        exp_q.delete();
    endtask

    task automatic set_req(input int i, input bit v, input int al);
        core_req[i].vld           = v;
        core_req[i].core_id       = 4'(i);
        core_req[i].access_length = 8'(al);
        core_req[i].we            = 1'($urandom);
        core_req[i].addr          = $urandom;
        core_req[i].data          = $urandom;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 0);
    endtask

    task automatic set_rsp(input bit v, input int id);
        mem_rsp.vld           = v;
        mem_rsp.core_id       = 4'(id);
        mem_rsp.access_length = 8'($urandom);
        mem_rsp.we            = 1'($urandom);
        mem_rsp.addr          = $urandom;
        mem_rsp.data          = $urandom;
    endtask

    // One clock cycle. Inputs are already driven at the negedge. The
    // combinational outputs are checked 1 ns later. The model advances, and
    // the registered outputs are checked 1 ns after the posedge. The task
    // returns at the next negedge.
    task automatic cycle();
        int s;
        int g;
        request_t e_req;
        logic [N-1:0] e_rdy;
        #1;
        s = -1;
        if (m_owner >= 0) begin
            if (core_req[m_owner].vld) s = m_owner;
        end else begin
            for (int k = 0; k < N; k++)
                if (s < 0 && core_req[(m_ptr + k) % N].vld) s = (m_ptr + k) % N;
        end
        e_req = '0;
        e_rdy = '0;
        if (s >= 0) e_req = core_req[s];
        g = (s >= 0 && mem_req_rdy) ? s : -1;
        if (g >= 0) e_rdy[g] = 1'b1;
        chk("mem_req", mem_req, e_req);
        chk("core_req_rdy", core_req_rdy, e_rdy);
        chk("burst_flag", dbg_state, (m_owner >= 0));
        last_rdy = core_req_rdy;
        for (int i = 0; i < N; i++) if (core_req_rdy[i]) acc_cnt[i]++;

        for (int i = 0; i < N; i++)
            exp_q.push_back((mem_rsp.vld && int'(mem_rsp.core_id) == i) ? mem_rsp : '0);
        if (mem_rsp.vld && int'(mem_rsp.core_id) >= N && m_bad < 65535) m_bad++;

        if (m_owner >= 0 && !core_req[m_owner].vld) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (g >= 0) begin
            if (m_owner < 0) begin
                m_owner = g;
                m_left  = clip(int'(core_req[g].access_length));
            end
            m_left--;
            if (m_left == 0) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) chk($sformatf("core_rsp%0d", i), core_rsp[i], exp_q.pop_front());
`ifdef MEM_INTERCONNECT_BAD_ID_CNT_EN
        chk("bad_id_cnt", bad_id_cnt, 16'(m_bad));
`else
        chk("bad_id_cnt", bad_id_cnt, 16'h0000);
`endif
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] one;
        request_t     rsp_sent;
        int           exp_bad;
        one = 1;

        // reset with every core requesting: outputs must stay quiet
        reset       = 1'b0;
        mem_req_rdy = 1'b1;
        set_rsp(1'b0, 0);
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1);
        model_reset();
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;
        #3;
        chk("rst_mem_req", mem_req, '0);
        chk("rst_rdy", core_req_rdy, '0);
        chk("rst_state", dbg_state, 1'b0);
        for (int i = 0; i < N; i++) chk($sformatf("rst_rsp%0d", i), core_rsp[i], '0);
        chk("rst_bad", bad_id_cnt, 16'h0000);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // fairness: single-beat requests from everyone rotate 0,1,2,3,...
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) set_req(i, 1'b1, 1);
            cycle();
            chk("fair_order", last_rdy, one << (k % N));
        end

        // move the pointer to 2
        clear_reqs();
        set_req(0, 1'b1, 1);
        set_req(1, 1'b1, 1);
        cycle();
        set_req(1, 1'b1, 1);
        set_req(0, 1'b1, 1);
        cycle();

        // burst lock: core 2 holds three beats ahead of core 0
        clear_reqs();
        set_req(2, 1'b1, 3);
        set_req(0, 1'b1, 1);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("lock_order", last_rdy, (k < 3) ? 4'b0100 : 4'b0001);
        end

        // clip to MAX_BURST with two stall cycles in the middle
        clear_reqs();
        set_req(1, 1'b1, 20);
        acc_cnt[1] = 0;
        for (int k = 0; k < 10; k++) begin
            mem_req_rdy = !(k == 3 || k == 4);
            cycle();
        end
        mem_req_rdy = 1'b1;
        chk("clip_beats", acc_cnt[1], 8);

        // abort: core 3 drops vld after its first of four beats
        clear_reqs();
        set_req(3, 1'b1, 4);
        set_req(0, 1'b1, 1);
        cycle();
        core_req[3].vld = 1'b0;
        cycle();
        chk("abort_quiet", last_rdy, 4'b0000);
        cycle();
        chk("abort_next", last_rdy, 4'b0001);

        // response routing: good id, then an out-of-range id
        clear_reqs();
        set_rsp(1'b1, 3);
        rsp_sent = mem_rsp;
        cycle();
        chk("route_hit", core_rsp[3], rsp_sent);
        set_rsp(1'b1, 5);
        cycle();
        chk("route_drop", core_rsp[3], '0);
`ifdef MEM_INTERCONNECT_BAD_ID_CNT_EN
        exp_bad = 1;
`else
        exp_bad = 0;
`endif
        chk("route_bad_cnt", bad_id_cnt, 16'(exp_bad));
        set_rsp(1'b0, 0);
        cycle();

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, 9) < 7, $urandom_range(0, 10));
            mem_req_rdy = ($urandom_range(0, 3) != 0);
            set_rsp($urandom_range(0, 1) == 1, $urandom_range(0, 7));
            cycle();
        end

        // reset in the middle of a burst
        clear_reqs();
        set_rsp(1'b0, 0);
        mem_req_rdy = 1'b1;
        cycle();
        set_req(2, 1'b1, 5);
        cycle();
        set_req(1, 1'b1, 1);
        set_req(2, 1'b1, 5);
        set_req(3, 1'b1, 1);
        set_rsp(1'b1, 2);
        cycle();
        reset = 1'b0;
        #1;
        chk("mid_rst_mem_req", mem_req, '0);
        chk("mid_rst_rdy", core_req_rdy, '0);
        chk("mid_rst_state", dbg_state, 1'b0);
        for (int i = 0; i < N; i++) chk($sformatf("mid_rst_rsp%0d", i), core_rsp[i], '0);
        model_reset();
        set_rsp(1'b0, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1);
        cycle();
        chk("post_rst_core0", last_rdy, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
